// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the multi-channel pulse generator.
package pulse_gen_pkg;

    // Channel fields are carried at the widest supported counter width so the
    // channel type is fixed; narrower counters zero-extend into it.
    localparam int CNT_W_MAX  = 16;
    localparam int CNT_W_DEF  = 13;
    localparam int PERIOD_DEF = 200;

    typedef struct packed {
        logic                 en;
        logic [CNT_W_MAX-1:0] delay;
        logic [CNT_W_MAX-1:0] width;
    } ch_cfg_t;

    // First counter value past the pulse; one extra bit so delay+width never wraps.
    function automatic logic [CNT_W_MAX:0] pulse_end(input ch_cfg_t c);
        return {1'b0, c.delay} + {1'b0, c.width};
    endfunction

endpackage

// File: rtl/pulse_channel.sv
// One output channel: shadow/active config, window compare, registered
// output pair and rise/fall strobes.
module pulse_channel
    import pulse_gen_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 commit,
    input  logic                 wr,
    input  ch_cfg_t              wr_cfg,
    input  logic [CNT_W_MAX-1:0] cnt,
    output logic                 signal,
    output logic                 signal_b,
    output logic                 pwm_set,
    output logic                 pwm_reset
);

    ch_cfg_t shadow;
    ch_cfg_t active;
    ch_cfg_t cfg_nx;
    logic    tgt;

    // A write landing on the commit edge goes straight through to active.
    assign cfg_nx = wr ? wr_cfg : shadow;

    // Pulse window; the counter never exceeds P-1, so the pulse is clipped
    // at the frame end without any explicit period compare.
    assign tgt = active.en & (cnt >= active.delay) & ({1'b0, cnt} < pulse_end(active));

    // Double-buffered channel configuration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
            active <= '0;
        end else begin
            shadow <= cfg_nx;
            if (commit)
                active <= cfg_nx;
        end
    end

    // Registered outputs; strobes compare the new target against the
    // current output, so they line up with the output change. With en low
    // everything clears, which also suppresses the fall strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            signal    <= 1'b0;
            signal_b  <= 1'b0;
            pwm_set   <= 1'b0;
            pwm_reset <= 1'b0;
        end else begin
            signal    <= en & tgt;
            signal_b  <= en & ~tgt;
            pwm_set   <= en & tgt & ~signal;
            pwm_reset <= en & ~tgt & signal;
        end
    end

endmodule

// File: rtl/multi_channel_pulse_gen.sv
// N-channel pulse generator: programmable frame counter, double-buffered
// period, per-channel delay/width committed at frame boundaries.
module multi_channel_pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int  N_CH       = 4,
    parameter int  CNT_W      = CNT_W_DEF,
    parameter int  DEF_PERIOD = PERIOD_DEF,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             period_we,
    input  logic [CNT_W-1:0] period,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic             cfg_ch_en,
    output logic             frame_tick,
    output logic             cfg_pending,
    output logic [N_CH-1:0]  signal,
    output logic [N_CH-1:0]  signal_b,
    output logic [N_CH-1:0]  PWMset,
    output logic [N_CH-1:0]  PWMreset,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] period_sh;
    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] period_nx;
    logic [CNT_W-1:0] p_eff;
    logic             wrap;
    logic             commit;
    logic             any_wr;
    logic [N_CH-1:0]  wr_sel;
    ch_cfg_t          wr_cfg;

    assign period_nx = period_we ? period : period_sh;

    // Frames shorter than two cycles are stretched to two.
    assign p_eff = (period_act < CNT_W'(2)) ? CNT_W'(2) : period_act;
    assign wrap  = (cnt >= p_eff - CNT_W'(1));

    // Every edge that lands on cnt==0 commits: the wrap, and every edge
    // while idle, so a restart always runs with the latest config.
    assign commit = ~en | wrap;

    assign wr_cfg     = {cfg_ch_en, CNT_W_MAX'(cfg_delay), CNT_W_MAX'(cfg_width)};
    assign any_wr     = period_we | (|wr_sel);
    assign frame_tick = en & (cnt == '0);

    // Frame counter: 0..P-1 while running, parked at 0 while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (!en || wrap)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    // Double-buffered frame period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_sh  <= CNT_W'(DEF_PERIOD);
            period_act <= CNT_W'(DEF_PERIOD);
        end else begin
            period_sh <= period_nx;
            if (commit)
                period_act <= period_nx;
        end
    end

    // Pending flag: set by any accepted write, cleared by the commit that
    // absorbs it (a write-through commit never raises it).
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cfg_pending <= 1'b0;
        else if (commit)
            cfg_pending <= 1'b0;
        else if (any_wr)
            cfg_pending <= 1'b1;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Out-of-range channel indices decode to no channel.
        assign wr_sel[i] = cfg_we & (cfg_ch == CH_W'(i));

        pulse_channel u_ch (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .commit    (commit),
            .wr        (wr_sel[i]),
            .wr_cfg    (wr_cfg),
            .cnt       (CNT_W_MAX'(cnt)),
            .signal    (signal[i]),
            .signal_b  (signal_b[i]),
            .pwm_set   (PWMset[i]),
            .pwm_reset (PWMreset[i])
        );
    end

endmodule

// File: tb/tb_multi_channel_pulse_gen.sv
// Randomized + directed bench against a frame-level reference model.
module tb_multi_channel_pulse_gen;

    localparam int N_CH  = 3;
    localparam int CNT_W = 13;
    localparam int CH_W  = 2;

    logic             clk = 1'b0;
    logic             reset, en, period_we, cfg_we, cfg_ch_en;
    logic [CNT_W-1:0] period, cfg_delay, cfg_width, cnt;
    logic [CH_W-1:0]  cfg_ch;
    logic             frame_tick, cfg_pending;
    logic [N_CH-1:0]  signal, signal_b, PWMset, PWMreset;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    int              m_cnt, m_psh, m_pact;
    int              s_d[N_CH], s_w[N_CH], a_d[N_CH], a_w[N_CH];
    bit              s_e[N_CH], a_e[N_CH];
    bit              m_pend;
    bit [N_CH-1:0]   m_sig, m_sigb, m_set, m_rst;

    multi_channel_pulse_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_PERIOD(200)) dut (
        .clk(clk), .reset(reset), .en(en), .period_we(period_we), .period(period),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .cfg_width(cfg_width),
        .cfg_ch_en(cfg_ch_en), .frame_tick(frame_tick), .cfg_pending(cfg_pending),
        .signal(signal), .signal_b(signal_b), .PWMset(PWMset), .PWMreset(PWMreset),
        .cnt(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit in_pulse(input int c, input int d, input int w, input bit e);
        return e && c >= d && c < d + w;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_psh = 200; m_pact = 200; m_pend = 0;
        m_sig = '0; m_sigb = '0; m_set = '0; m_rst = '0;
        for (int i = 0; i < N_CH; i++) begin
            s_d[i] = 0; s_w[i] = 0; s_e[i] = 0; a_d[i] = 0; a_w[i] = 0; a_e[i] = 0;
        end
    endtask

    // Applies one clock edge of the specified behaviour to the model.
    task automatic model_edge();
        bit [N_CH-1:0] h;
        int  pe;
        bit  at_end, cmt, anyw;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N_CH; i++) begin
            h[i]     = in_pulse(m_cnt, a_d[i], a_w[i], a_e[i]);
            m_set[i] = en && h[i] && !m_sig[i];
            m_rst[i] = en && !h[i] && m_sig[i];
            m_sig[i] = en && h[i];
            m_sigb[i] = en && !h[i];
        end
        pe     = (m_pact < 2) ? 2 : m_pact;
        at_end = en && (m_cnt == pe - 1);
        cmt    = !en || at_end;
        anyw   = period_we;
        if (period_we) m_psh = int'(period);
        if (cfg_we && int'(cfg_ch) < N_CH) begin
            anyw = 1;
            s_d[cfg_ch] = int'(cfg_delay);
            s_w[cfg_ch] = int'(cfg_width);
            s_e[cfg_ch] = cfg_ch_en;
        end
        if (cmt) begin
            m_pact = m_psh;
            for (int i = 0; i < N_CH; i++) begin
                a_d[i] = s_d[i]; a_w[i] = s_w[i]; a_e[i] = s_e[i];
            end
        end
        m_pend = cmt ? 1'b0 : (m_pend || anyw);
        m_cnt  = (!en || at_end) ? 0 : m_cnt + 1;
    endtask

    task automatic compare_all();
        chk("cnt", cnt, m_cnt);
        chk("frame_tick", frame_tick, en && m_cnt == 0);
        chk("cfg_pending", cfg_pending, m_pend);
        chk("signal", signal, m_sig);
        chk("signal_b", signal_b, m_sigb);
        chk("PWMset", PWMset, m_set);
        chk("PWMreset", PWMreset, m_rst);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wr_ch(input int ch, input int d, input int w, input bit e);
        cfg_we = 1; cfg_ch = CH_W'(ch); cfg_delay = CNT_W'(d); cfg_width = CNT_W'(w); cfg_ch_en = e;
        step();
        cfg_we = 0;
    endtask

    task automatic wr_per(input int p);
        period_we = 1; period = CNT_W'(p);
        step();
        period_we = 0;
    endtask

    task automatic run_to_cnt(input int target);
        int n = 0;
        while (m_cnt != target && n < 1000) begin step(); n++; end
        if (m_cnt != target) chk("run_to_cnt_timeout", m_cnt, target);
    endtask

    initial begin
        int first_set, first_rst, t0, t1, n, ticks;
        reset = 1; en = 0; period_we = 0; period = '0; cfg_we = 0; cfg_ch = '0;
        cfg_delay = '0; cfg_width = '0; cfg_ch_en = 0;
        model_reset();
        #1;
        chk("reset_cnt", cnt, 0);
        chk("reset_signal", signal, 0);
        chk("reset_pending", cfg_pending, 0);
        repeat (3) step();
        reset = 0;
        step();

        // 1: basic pulse D=10 Wd=20, P=200
        wr_ch(0, 10, 20, 1);
        en = 1;
        first_set = -1; first_rst = -1; t0 = -1; t1 = -1;
        for (int c = 0; c < 450; c++) begin
            step();
            if (PWMset[0] && first_set < 0) first_set = int'(cnt);
            if (PWMreset[0] && first_rst < 0) first_rst = int'(cnt);
            if (frame_tick) begin
                if (t0 < 0) t0 = c; else if (t1 < 0) t1 = c;
            end
        end
        chk("t1_set_cnt", first_set, 11);
        chk("t1_reset_cnt", first_rst, 31);
        chk("t1_tick_spacing", t1 - t0, 200);

        // 2: mid-frame width change
        run_to_cnt(100);
        wr_ch(0, 10, 50, 1);
        chk("t2_pending", cfg_pending, 1);
        run_to_cnt(0);
        n = 0;
        for (int c = 0; c < 200; c++) begin step(); n += signal[0]; end
        chk("t2_width_next_frame", n, 50);

        // 3: pulse at frame end, out-of-range channel write ignored
        run_to_cnt(50);
        wr_ch(3, 1, 5, 1);
        chk("t5_bad_ch_pending", cfg_pending, 0);
        wr_ch(1, 190, 50, 1);
        repeat (420) step();

        // 4: zero width, and full-frame hold with a single rise
        wr_ch(1, 5, 0, 1);
        wr_ch(2, 0, 300, 1);
        run_to_cnt(0);
        n = 0; ticks = 0;
        for (int c = 0; c < 600; c++) begin
            step();
            n += signal[1];
            ticks += PWMset[2];
        end
        chk("t4_zero_width_high", n, 0);
        chk("t4_hold_sets", ticks, 1);
        chk("t4_hold_high", signal[2], 1);

        // 5: period 1 clamps to 2
        wr_per(1);
        run_to_cnt(0);
        step();
        ticks = 0;
        for (int c = 0; c < 20; c++) begin step(); ticks += frame_tick; end
        chk("t5_ticks_p2", ticks, 10);

        // 6: en drop mid-pulse, then async reset
        wr_per(200);
        wr_ch(0, 10, 20, 1);
        run_to_cnt(0);
        run_to_cnt(15);
        en = 0;
        n = 0;
        for (int c = 0; c < 37; c++) begin step(); n += PWMreset[0]; end
        chk("t6_no_reset_strobe", n, 0);
        en = 1;
        first_set = -1;
        for (int c = 0; c < 60; c++) begin
            step();
            if (PWMset[0] && first_set < 0) first_set = int'(cnt);
        end
        chk("t6_restart_set_cnt", first_set, 11);
        run_to_cnt(18);
        #2 reset = 1;
        #1;
        chk("t6_async_cnt", cnt, 0);
        chk("t6_async_signal", signal, 0);
        chk("t6_async_signal_b", signal_b, 0);
        step();
        step();
        reset = 0;
        repeat (250) step();

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(99) < 2) en = ~en;
            period_we = ($urandom_range(99) < 3);
            period = CNT_W'($urandom_range(60));
            cfg_we = ($urandom_range(99) < 10);
            cfg_ch = CH_W'($urandom_range(3));
            cfg_delay = CNT_W'($urandom_range(45));
            cfg_width = CNT_W'($urandom_range(50));
            cfg_ch_en = ($urandom_range(9) != 0);
            if ($urandom_range(999) == 0) begin
                #2 reset = 1;
                step();
                reset = 0;
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
